// File: rtl/axi4_lite_regfile.sv
// axi4_lite_regfile: parametrised AXI4-Lite slave register file with byte strobes and hardware-sourced read-only registers
module axi4_lite_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          awaddr_i,
    input  logic                           awvalid_i,
    output logic                           awready_o,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
    input  logic                           wvalid_i,
    output logic                           wready_o,
    output logic [1:0]                     bresp_o,
    output logic                           bvalid_o,
    input  logic                           bready_i,
    input  logic [ADDR_WIDTH-1:0]          araddr_i,
    input  logic                           arvalid_i,
    output logic                           arready_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [1:0]                     rresp_o,
    output logic                           rvalid_o,
    input  logic                           rready_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data_i
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;
    logic aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0] wstrb_q, wstrb_d;
    logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] cur [NUM_REGS];
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, wr_ok, wr_en, rd_ok;
    logic [IW-1:0] wr_idx, rd_idx;

    function automatic logic dec_ok(input logic [ADDR_WIDTH-1:0] a);
        return (((a - BASE_ADDR) & ADDR_WIDTH'(NB - 1)) == '0) &&
               (((a - BASE_ADDR) >> LSB) < ADDR_WIDTH'(NUM_REGS));
    endfunction

    function automatic logic [IW-1:0] dec_idx(input logic [ADDR_WIDTH-1:0] a);
        return IW'((a - BASE_ADDR) >> LSB);
    endfunction

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign cur[i] = RO_MASK[i] ? ro_data_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = cur[i];
    end

    assign aw_hs  = awvalid_i & awready_q;
    assign w_hs   = wvalid_i & wready_q;
    assign b_hs   = bvalid_q & bready_i;
    assign ar_hs  = arvalid_i & arready_q;
    assign r_hs   = rvalid_q & rready_i;
    assign commit = wstate_q == W_IDLE && aw_have_q && w_have_q;
    assign wr_ok  = dec_ok(awaddr_q);
    assign wr_idx = dec_idx(awaddr_q);
    assign wr_en  = commit && wr_ok && !RO_MASK[wr_idx];
    assign rd_ok  = dec_ok(araddr_i);
    assign rd_idx = dec_idx(araddr_i);

    always_comb begin
        wstate_d  = commit ? W_RESP : b_hs ? W_IDLE : wstate_q;
        aw_have_d = !commit && (aw_have_q || aw_hs);
        w_have_d  = !commit && (w_have_q || w_hs);
        awaddr_d  = aw_hs ? awaddr_i : awaddr_q;
        wdata_d   = w_hs ? wdata_i : wdata_q;
        wstrb_d   = w_hs ? wstrb_i : wstrb_q;
        bvalid_d  = commit || (bvalid_q && !bready_i);
        bresp_d   = !commit ? bresp_q : !wr_ok ? 2'b11 : RO_MASK[wr_idx] ? 2'b10 : 2'b00;
        awready_d = wstate_d == W_IDLE && !aw_have_d;
        wready_d  = wstate_d == W_IDLE && !w_have_d;
        rstate_d  = ar_hs ? R_DATA : r_hs ? R_IDLE : rstate_q;
        arready_d = rstate_d == R_IDLE;
        rvalid_d  = ar_hs || (rvalid_q && !rready_i);
        rdata_d   = !ar_hs ? rdata_q : rd_ok ? cur[rd_idx] : '0;
        rresp_d   = !ar_hs ? rresp_q : rd_ok ? 2'b00 : 2'b11;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++)
            for (int b = 0; b < NB; b++)
                if (reset)
                    regs_q[i][8*b +: 8] <= '0;
                else if (wr_en && wr_idx == IW'(i) && wstrb_q[b])
                    regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// tb_axi4_lite_regfile: directed and randomized AXI4-Lite traffic checked against a register-array model
module tb_axi4_lite_regfile;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam logic [NR-1:0] ROM = 8'h01;

    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] awaddr_i, araddr_i;
    logic awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i;
    logic arvalid_i, arready_o, rvalid_o, rready_i;
    logic [DW-1:0] wdata_i, rdata_o;
    logic [DW/8-1:0] wstrb_i;
    logic [1:0] bresp_o, rresp_o;
    logic [NR*DW-1:0] regs_o, ro_data_i;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] mem [NR];

    axi4_lite_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR('0), .RO_MASK(ROM)) dut (
        .clk(clk), .reset(reset),
        .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .regs_o(regs_o), .ro_data_i(ro_data_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [AW-1:0] a, input bit is_wr);
        if (a % 4 != 0 || a / 4 >= NR) return 2'b11;
        if (is_wr && ROM[a/4]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [DW-1:0] exp_reg(input int i);
        return ROM[i] ? ro_data_i[i*DW +: DW] : mem[i];
    endfunction

    task automatic check_regs();
        for (int i = 0; i < NR; i++) check($sformatf("regs_o[%0d]", i), regs_o[i*DW +: DW], exp_reg(i));
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                             input int ad, input int wd, input int hold);
        bit a_done = 0;
        bit w_done = 0;
        bit ha, hw;
        int n = 0;
        int k = 0;
        logic [1:0] r;
        r = exp_resp(a, 1);
        awaddr_i = a; wdata_i = d; wstrb_i = s; bready_i = (hold == 0);
        while (!(a_done && w_done) && n < 100) begin
            awvalid_i = !a_done && n >= ad;
            wvalid_i = !w_done && n >= wd;
            if (w_done && !a_done) begin
                check("wready_after_w", wready_o, 0);
                check("awready_wait_aw", awready_o, 1);
                check("no_early_bvalid", bvalid_o, 0);
            end
            ha = awvalid_i && awready_o;
            hw = wvalid_i && wready_o;
            @(negedge clk);
            a_done |= ha; w_done |= hw; n++;
        end
        awvalid_i = 0; wvalid_i = 0;
        check("w_handshake", a_done && w_done, 1);
        while (!bvalid_o && k < 20) begin @(negedge clk); k++; end
        check("b_latency", k, 1);
        if (r == 2'b00)
            for (int b = 0; b < 4; b++) if (s[b]) mem[a/4][8*b +: 8] = d[8*b +: 8];
        check("bresp", bresp_o, r);
        check_regs();
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check("bvalid_hold", bvalid_o, 1);
            check("bresp_hold", bresp_o, r);
            check("awready_hold", awready_o, 0);
        end
        bready_i = 1;
        @(negedge clk);
        check("b_done", bvalid_o, 0);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int hold);
        bit done = 0;
        bit h;
        int n = 0;
        logic [1:0] r;
        logic [DW-1:0] d;
        r = exp_resp(a, 0);
        d = '0;
        if (r == 2'b00) d = exp_reg(int'(a / 4));
        araddr_i = a; rready_i = (hold == 0);
        while (!done && n < 100) begin
            arvalid_i = 1;
            h = arready_o;
            @(negedge clk);
            done = h; n++;
        end
        arvalid_i = 0;
        check("ar_handshake", done, 1);
        check("rvalid", rvalid_o, 1);
        check("rdata", rdata_o, d);
        check("rresp", rresp_o, r);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check("rvalid_hold", rvalid_o, 1);
            check("rdata_hold", rdata_o, d);
            check("arready_hold", arready_o, 0);
        end
        rready_i = 1;
        @(negedge clk);
        check("r_done", rvalid_o, 0);
    endtask

    initial begin
        logic [AW-1:0] addr;
        int sel;
        reset = 1; awvalid_i = 0; wvalid_i = 0; arvalid_i = 0; bready_i = 1; rready_i = 1;
        awaddr_i = '0; araddr_i = '0; wdata_i = '0; wstrb_i = '0;
        for (int i = 0; i < NR; i++) begin ro_data_i[i*DW +: DW] = $urandom; mem[i] = '0; end
        repeat (2) @(negedge clk);
        check("rst_awready", awready_o, 0);
        check("rst_wready", wready_o, 0);
        check("rst_bvalid", bvalid_o, 0);
        check("rst_arready", arready_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_resp", {bresp_o, rresp_o}, 0);
        check("rst_rdata", rdata_o, 0);
        check_regs();
        reset = 0;
        repeat (2) @(negedge clk);
        check("idle_awready", awready_o, 1);
        check("idle_arready", arready_o, 1);

        axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        check("reg1_deadbeef", regs_o[63:32], 32'hDEADBEEF);
        axi_read(32'h4, 0);
        axi_write(32'h8, 32'h11223344, 4'hF, 3, 0, 0);
        axi_write(32'h8, 32'hAABBCCDD, 4'h5, 0, 0, 0);
        check("reg2_partial", regs_o[95:64], 32'h11BB33DD);
        ro_data_i[31:0] = 32'hCAFE0000;
        axi_write(32'h0, 32'h12345678, 4'hF, 0, 0, 0);
        check("reg0_ro", regs_o[31:0], 32'hCAFE0000);
        axi_read(32'h0, 0);
        axi_read(32'h20, 0);
        axi_read(32'h2, 0);
        axi_write(32'h10, 32'h0BADF00D, 4'h0, 0, 0, 0);
        axi_write(32'hC, 32'h5A5A1234, 4'hF, 1, 2, 5);
        axi_read(32'hC, 5);

        bready_i = 0; rready_i = 0;
        awaddr_i = 32'h8; wdata_i = 32'h55667788; wstrb_i = 4'hF; araddr_i = 32'h4;
        awvalid_i = 1; wvalid_i = 1; arvalid_i = 1;
        @(negedge clk);
        awvalid_i = 0; wvalid_i = 0; arvalid_i = 0;
        @(negedge clk);
        check("pre_rst_bvalid", bvalid_o, 1);
        check("pre_rst_rvalid", rvalid_o, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < NR; i++) mem[i] = '0;
        check("mid_rst_bvalid", bvalid_o, 0);
        check("mid_rst_rvalid", rvalid_o, 0);
        check_regs();
        @(negedge clk);
        check("post_rst_awready", awready_o, 1);
        check("post_rst_wready", wready_o, 1);
        check("post_rst_arready", arready_o, 1);
        check("post_rst_bvalid", bvalid_o, 0);
        bready_i = 1; rready_i = 1;
        axi_write(32'h8, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        axi_read(32'h8, 0);

        repeat (60) begin
            for (int i = 0; i < NR; i++) ro_data_i[i*DW +: DW] = $urandom;
            sel = $urandom_range(0, 9);
            addr = sel < 7 ? AW'($urandom_range(0, 7) * 4) :
                   sel == 7 ? AW'(32'h20 + $urandom_range(0, 7) * 4) :
                   sel == 8 ? AW'($urandom_range(0, 7) * 4 + $urandom_range(1, 3)) : AW'($urandom);
            if ($urandom_range(0, 1) == 1)
                axi_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(addr, $urandom_range(0, 2));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
